ex_muldiv_ctrl: RTL and testbench
=================================

Name: ex_muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer beside the EX stage. It owns the HI/LO registers and the iterative mult/div datapath. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from EX and stalls the pipeline while an operation is in flight. EX ALU results for these ops come from this block's read port.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset (`RST_ENABLE); sampled on clk.
- start_i  in  1  op_i valid from EX this cycle.
- op_i  in  6  decoded opcode (`op_mult, `op_multu, `op_div, `op_divu, `op_mfhi, `op_mflo, `op_mthi, `op_mtlo).
- regaData  in  WIDTH  operand A / dividend / MTHI-MTLO source.
- regbData  in  WIDTH  operand B / divisor.
- stall_o  out  1  holds IF/ID/EX; combinational.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse in DONE.
- regcData  out  WIDTH  MFHI/MFLO result; combinational.
- hi_o  out  WIDTH  current HI register.
- lo_o  out  WIDTH  current LO register.

Behaviour:
- Reset: state=IDLE; hi=lo=0; counter=0; all outputs 0. Reset mid-operation aborts it, discards partial results and leaves HI/LO at 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start_i with MULT/MULTU: latch |A|,|B| (signed) or raw A,B (unsigned); record result sign; go to MUL; counter=0.
- IDLE, start_i with DIV/DIVU and B!=0: latch magnitudes similarly; record quotient sign (A^B) and remainder sign (A); go to DIV.
- IDLE, start_i with DIV/DIVU and B==0: go directly to DONE with lo=all-ones, hi=A.
- MUL: one shift-add step per cycle, 32 steps. Go to DONE after step 31.
- DIV: one restoring step per cycle, 32 steps. Go to DONE after step 31.
- DONE: apply signed correction (two's-complement negate as recorded); write HI/LO at end of cycle; done_o=1; return to IDLE.
- Latency: start at cycle T gives DONE at T+33 and HI/LO valid from T+34. Divide-by-zero gives DONE at T+1.
- MULT result: {hi,lo} = 64-bit product.
- DIV result: lo = quotient, hi = remainder. Remainder sign follows the dividend. 0x80000000 / -1 gives lo=0x80000000, hi=0 with no trap.
- MTHI/MTLO in IDLE: hi (or lo) = regaData at end of cycle; no stall.
- MFHI/MFLO in IDLE: regcData = hi/lo combinationally; no stall. For all other ops regcData = 0.
- stall_o = 1 when:
  - start_i with a mult/div op in IDLE, or
  - state is MUL or DIV, or
  - start_i with any muldiv op while busy.
  stall_o = 0 in DONE, so the held instruction proceeds and reads the new HI/LO the next cycle.
- start_i while busy is ignored (not queued). EX re-presents the op because it is stalled.
- An op outside the muldiv set: no effect, no stall.

Optional Feature:
- FAST_MUL_EN defined: MULT/MULTU go IDLE -> DONE using the `*` operator (signed/unsigned 64-bit product). Latency is 2 cycles and the MUL state is unused.
- FAST_MUL_EN undefined: 32-step iterative path as above. DIV is iterative in both builds.

Decomposition:
- def.v gains:
  - the eight muldiv opcode macros (distinct from existing op_ codes);
  - the state encodings `MD_IDLE/`MD_MUL/`MD_DIV/`MD_DONE;
  - `MD_ITER = 32.
- Sub-module muldiv_iter: the one-step shift-add / restoring-subtract datapath (64-bit accumulator, step select, mul/div select).
- ex_muldiv_ctrl keeps the FSM, counter, sign fixup, HI/LO and stall logic.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> stall for 33 cycles, done_o at T+33, hi=0xFFFFFFFE, lo=0x00000001.
- MULT A=-7 (0xFFFFFFF9) B=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; with FAST_MUL_EN the same result at T+1.
- DIV A=-7 B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU A=7 B=2 -> lo=3, hi=1.
- DIVU A=0x1234 B=0 -> DONE at T+1, lo=0xFFFFFFFF, hi=0x1234; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MFLO issued the cycle after MULT start -> stall_o=1 until DONE, then regcData=new lo. MTHI 0xA5A5A5A5 in IDLE -> hi_o=0xA5A5A5A5 next cycle, stall_o=0.
- rst=1 at iteration 10 of DIV -> next cycle state IDLE, hi=lo=0, stall_o=0, busy_o=0; a new MULT 3*4 then gives lo=12.

Source files
------------

// File: rtl/ex_muldiv_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ex_muldiv_ctrl_pkg
// Shared definitions for the EX-stage multiply/divide sequencer:
//   - the eight muldiv opcodes carried on op_i
//   - the sequencer state encoding
//   - the default iteration count for the 32-bit datapath
//   - opcode classification helpers
// ----------------------------------------------------------------------------
package ex_muldiv_ctrl_pkg;

   // Muldiv opcodes, kept clear of the other EX op codes.
   localparam logic [5:0] OP_MFHI  = 6'h10;
   localparam logic [5:0] OP_MTHI  = 6'h11;
   localparam logic [5:0] OP_MFLO  = 6'h12;
   localparam logic [5:0] OP_MTLO  = 6'h13;
   localparam logic [5:0] OP_MULT  = 6'h18;
   localparam logic [5:0] OP_MULTU = 6'h19;
   localparam logic [5:0] OP_DIV   = 6'h1A;
   localparam logic [5:0] OP_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MUL  = 2'd1,
      MD_DIV  = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

   // Number of shift-add / restoring steps for the default 32-bit width.
   localparam int MD_ITER = 32;

   // Ops that occupy the iterative datapath and therefore stall EX.
   function automatic logic is_arith(input logic [5:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Any op this block responds to.
   function automatic logic is_muldiv(input logic [5:0] op);
      return is_arith(op) || (op == OP_MFHI) || (op == OP_MFLO) ||
             (op == OP_MTHI) || (op == OP_MTLO);
   endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// ----------------------------------------------------------------------------
// ex_muldiv_ctrl_if
// EX <-> muldiv sequencer connection.
//   master (EX side)    : drives start_i, op_i, regaData, regbData
//   slave  (sequencer)  : drives stall_o, busy_o, done_o, regcData, hi_o, lo_o
// ----------------------------------------------------------------------------
interface ex_muldiv_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start_i;   // op_i valid this cycle
   logic [5:0]       op_i;      // decoded opcode
   logic [WIDTH-1:0] regaData;  // operand A / dividend / MTHI-MTLO source
   logic [WIDTH-1:0] regbData;  // operand B / divisor
   logic             stall_o;   // hold IF/ID/EX
   logic             busy_o;    // sequencer not idle
   logic             done_o;    // one-cycle completion pulse
   logic [WIDTH-1:0] regcData;  // MFHI/MFLO read data
   logic [WIDTH-1:0] hi_o;      // HI register
   logic [WIDTH-1:0] lo_o;      // LO register

   modport master (
      output start_i, op_i, regaData, regbData,
      input  stall_o, busy_o, done_o, regcData, hi_o, lo_o
   );

   modport slave (
      input  start_i, op_i, regaData, regbData,
      output stall_o, busy_o, done_o, regcData, hi_o, lo_o
   );
endinterface

// File: rtl/ex_muldiv_ctrl_muldiv_iter.sv
// ----------------------------------------------------------------------------
// muldiv_iter
// One step of the iterative multiply/divide datapath, purely combinational.
//   is_div   in  1        0: shift-add multiply step, 1: restoring divide step
//   acc      in  2*WIDTH  accumulator {upper, lower}
//   opb      in  WIDTH    multiplicand (mul) or divisor magnitude (div)
//   acc_next out 2*WIDTH  accumulator after this step
//
// Multiply: lower half starts as the multiplier. Each step adds opb into the
// upper half when the current multiplier LSB is set, then shifts the whole
// 65-bit {carry, acc} right by one. After WIDTH steps acc is the product.
//
// Divide: acc starts as {0, dividend}. Each step shifts left by one, trial
// subtracts opb from the upper half, and shifts the quotient bit in at the
// bottom. After WIDTH steps acc = {remainder, quotient}.
// ----------------------------------------------------------------------------
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   opb,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0] mul_sum;   // upper half + addend, with carry
   logic [WIDTH:0] div_part;  // partial remainder after the left shift
   logic [WIDTH:0] div_diff;  // trial subtraction
   logic           div_ge;    // trial subtraction succeeds

   // NOTE: every signal written in an always_comb gets a value on every path
   // (here, unconditionally first) so no latch is inferred.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
      div_part = acc[2*WIDTH-1:WIDTH-1];
      div_diff = div_part - {1'b0, opb};
      div_ge   = (div_part >= {1'b0, opb});

      if (is_div) begin
         // Partial remainder is always below 2*opb, so WIDTH+1 bits suffice
         // and the restored value fits back into WIDTH bits.
         if (div_ge) begin
            acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_next = {mul_sum, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// ex_muldiv_ctrl
// Multi-cycle multiply/divide sequencer beside the EX stage. Owns HI/LO and
// the iterative mult/div datapath, and stalls the pipeline while busy.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   bus   slave modport of ex_muldiv_ctrl_if:
//           start_i, op_i, regaData, regbData  (from EX)
//           stall_o, busy_o, done_o, regcData, hi_o, lo_o (to EX)
//
// Build option:
//   FAST_MUL_EN  defined: MULT/MULTU compute the product with '*' and go
//                straight IDLE -> DONE. Undefined: 32-step shift-add path.
//                DIV/DIVU are iterative in both builds.
//
// Timing (iterative): start in cycle T, MUL/DIV for T+1..T+32, DONE at T+33,
// HI/LO hold the new values from T+34. Divide-by-zero reaches DONE at T+1.
// ----------------------------------------------------------------------------
module ex_muldiv_ctrl
   import ex_muldiv_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   ex_muldiv_ctrl_if.slave   bus
);

   md_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic                 neg_lo_q, neg_lo_d;  // negate product / quotient
   logic                 neg_hi_q, neg_hi_d;  // negate remainder
   logic                 is_div_q, is_div_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   logic [2*WIDTH-1:0]   acc_step;
   logic                 signed_op;
   logic                 a_neg, b_neg;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     res_hi, res_lo;

`ifdef FAST_MUL_EN
   logic [2*WIDTH-1:0]   prod_u, prod_s;

   assign prod_u = {{WIDTH{1'b0}}, bus.regaData} * {{WIDTH{1'b0}}, bus.regbData};
   assign prod_s = $unsigned($signed({{WIDTH{bus.regaData[WIDTH-1]}}, bus.regaData}) *
                             $signed({{WIDTH{bus.regbData[WIDTH-1]}}, bus.regbData}));
`endif

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .is_div   (is_div_q),
      .acc      (acc_q),
      .opb      (opb_q),
      .acc_next (acc_step)
   );

   // Operand magnitudes: signed ops iterate on |A|, |B| and fix the sign at
   // the end; unsigned ops pass the raw operands through.
   always_comb begin
      signed_op = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
      a_neg     = signed_op && bus.regaData[WIDTH-1];
      b_neg     = signed_op && bus.regbData[WIDTH-1];
      a_mag     = a_neg ? (~bus.regaData + 1'b1) : bus.regaData;
      b_mag     = b_neg ? (~bus.regbData + 1'b1) : bus.regbData;
   end

   // Signed correction of the finished accumulator. Remainder takes the
   // dividend's sign; quotient takes A^B. 0x80000000 / -1 needs no special
   // case: the magnitude quotient 0x80000000 is left un-negated.
   always_comb begin
      prod_fix = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
      if (is_div_q) begin
         res_lo = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
         res_hi = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
      end else begin
         res_lo = prod_fix[WIDTH-1:0];
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      is_div_d = is_div_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      unique case (state_q)
         MD_IDLE: begin
            if (bus.start_i) begin
               case (bus.op_i)
                  OP_MULT, OP_MULTU: begin
`ifdef FAST_MUL_EN
                     acc_d    = (bus.op_i == OP_MULT) ? prod_s : prod_u;
                     neg_lo_d = 1'b0;
                     neg_hi_d = 1'b0;
                     is_div_d = 1'b0;
                     state_d  = MD_DONE;
`else
                     acc_d    = {{WIDTH{1'b0}}, a_mag};
                     opb_d    = b_mag;
                     neg_lo_d = a_neg ^ b_neg;
                     neg_hi_d = 1'b0;
                     is_div_d = 1'b0;
                     cnt_d    = '0;
                     state_d  = MD_MUL;
`endif
                  end
                  OP_DIV, OP_DIVU: begin
                     is_div_d = 1'b1;
                     if (bus.regbData == '0) begin
                        // Divide by zero: raw A to HI, all-ones to LO.
                        acc_d    = {bus.regaData, {WIDTH{1'b1}}};
                        neg_lo_d = 1'b0;
                        neg_hi_d = 1'b0;
                        state_d  = MD_DONE;
                     end else begin
                        acc_d    = {{WIDTH{1'b0}}, a_mag};
                        opb_d    = b_mag;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg;
                        cnt_d    = '0;
                        state_d  = MD_DIV;
                     end
                  end
                  OP_MTHI: hi_d = bus.regaData;
                  OP_MTLO: lo_d = bus.regaData;
                  default: ;
               endcase
            end
         end

         MD_MUL, MD_DIV: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = MD_DONE;
            end
         end

         MD_DONE: begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            state_d = MD_IDLE;
         end

         default: state_d = MD_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples its pre-edge value regardless of statement order.
   // NOTE: the datapath registers are reset too, so an aborted operation
   // leaves no partial result behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MD_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         is_div_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         is_div_q <= is_div_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   // Outputs. Stall drops in DONE so the held instruction moves on; the read
   // port forwards the corrected result in DONE so a held MFHI/MFLO sees it.
   always_comb begin
      bus.busy_o   = (state_q != MD_IDLE);
      bus.done_o   = (state_q == MD_DONE);
      bus.hi_o     = hi_q;
      bus.lo_o     = lo_q;
      bus.stall_o  = 1'b0;
      bus.regcData = '0;

      if (!rst) begin
         bus.stall_o = ((state_q == MD_IDLE) && bus.start_i && is_arith(bus.op_i)) ||
                       (state_q == MD_MUL) || (state_q == MD_DIV);
         if (state_q == MD_IDLE) begin
            if (bus.op_i == OP_MFHI) bus.regcData = hi_q;
            if (bus.op_i == OP_MFLO) bus.regcData = lo_q;
         end else if (state_q == MD_DONE) begin
            if (bus.op_i == OP_MFHI) bus.regcData = res_hi;
            if (bus.op_i == OP_MFLO) bus.regcData = res_lo;
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_ctrl
// Self-checking bench for ex_muldiv_ctrl. Stimulus pushes the expected HI/LO
// and DONE cycle into a scoreboard queue; a monitor pops and compares each
// time done_o is seen. Stall, reset and move/read-port behaviour are checked
// directly by the stimulus process.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_ctrl;
   import ex_muldiv_ctrl_pkg::*;

`ifdef FAST_MUL_EN
   localparam int LAT_MUL = 1;
`else
   localparam int LAT_MUL = 33;
`endif
   localparam int LAT_DIV  = 33;
   localparam int LAT_DIV0 = 1;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          done_cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_tests;
   int   n_fail;
   exp_t sb[$];

   ex_muldiv_ctrl_if #(.WIDTH(32)) bus ();

   ex_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: on done_o, pop the next expectation, check the DONE cycle, and
   // check HI/LO one cycle later once they have been written.
   exp_t cur;
   bit   pend;
   always @(negedge clk) begin
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            check({cur.name, "_hi"}, bus.hi_o, cur.hi);
            check({cur.name, "_lo"}, bus.lo_o, cur.lo);
            pend = 1'b0;
         end
         if (bus.done_o) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: done_o=1 at cycle %0d, expected no pending op", cyc);
            end else begin
               cur = sb.pop_front();
               check({cur.name, "_done_cyc"}, cyc, cur.done_cyc);
               pend = 1'b1;
            end
         end
      end
   end

   // Issue one arithmetic op for one cycle, push its expectation, count the
   // stall cycles up to DONE and check stall_o is low in DONE.
   task automatic run_op(input string name, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int lat);
      int   t0;
      int   stall_cnt;
      bit   got;
      exp_t e;
      @(posedge clk); #1;
      bus.start_i  = 1'b1;
      bus.op_i     = op;
      bus.regaData = a;
      bus.regbData = b;
      t0 = cyc;
      e.name = name; e.hi = exp_hi; e.lo = exp_lo; e.done_cyc = t0 + lat;
      sb.push_back(e);
      stall_cnt = 0;
      got = 1'b0;
      @(negedge clk);
      if (bus.stall_o) stall_cnt++;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         if (bus.done_o) begin
            got = 1'b1;
            check({name, "_stall_in_done"}, bus.stall_o, 0);
         end else if (bus.stall_o) begin
            stall_cnt++;
         end
      end
      check({name, "_done_seen"}, got, 1);
      check({name, "_stall_cycles"}, stall_cnt, lat);
      @(negedge clk);
      @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  t0;
      bit  got;
      bit  stall_ok;
      exp_t e;

      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      rst     = 1'b1;
      bus.start_i  = 1'b0;
      bus.op_i     = '0;
      bus.regaData = '0;
      bus.regbData = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      @(negedge clk);
      check("rst_hi",    bus.hi_o,     0);
      check("rst_lo",    bus.lo_o,     0);
      check("rst_busy",  bus.busy_o,   0);
      check("rst_stall", bus.stall_o,  0);
      check("rst_done",  bus.done_o,   0);
      check("rst_regc",  bus.regcData, 0);

      // Multiply and divide vectors.
      run_op("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT_MUL);
      run_op("mult_m7x3",  OP_MULT,  32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, LAT_MUL);
      run_op("mult_ext",   OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, LAT_MUL);
      run_op("multu_2p32", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, LAT_MUL);
      run_op("div_m7d2",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_DIV);
      run_op("div_7dm2",   OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, LAT_DIV);
      run_op("divu_7d2",   OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, LAT_DIV);
      run_op("divu_by0",   OP_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, LAT_DIV0);
      run_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, LAT_DIV);

      // Moves and read port.
      @(posedge clk); #1;
      bus.start_i = 1'b1; bus.op_i = OP_MTHI; bus.regaData = 32'hA5A5_A5A5;
      @(negedge clk);
      check("mthi_stall", bus.stall_o, 0);
      @(posedge clk); #1;
      bus.op_i = OP_MTLO; bus.regaData = 32'h5A5A_5A5A;
      @(negedge clk);
      check("mthi_hi", bus.hi_o, 32'hA5A5_A5A5);
      check("mtlo_stall", bus.stall_o, 0);
      @(posedge clk); #1;
      bus.op_i = OP_MFHI;
      @(negedge clk);
      check("mtlo_lo", bus.lo_o, 32'h5A5A_5A5A);
      check("mfhi_regc", bus.regcData, 32'hA5A5_A5A5);
      check("mfhi_stall", bus.stall_o, 0);
      @(posedge clk); #1;
      bus.op_i = OP_MFLO;
      @(negedge clk);
      check("mflo_regc", bus.regcData, 32'h5A5A_5A5A);
      @(posedge clk); #1;
      bus.op_i = 6'h20; bus.regaData = 32'h1111_1111;
      @(negedge clk);
      check("other_regc",  bus.regcData, 0);
      check("other_stall", bus.stall_o, 0);
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      @(negedge clk);
      check("other_hi_kept", bus.hi_o, 32'hA5A5_A5A5);
      check("other_lo_kept", bus.lo_o, 32'h5A5A_5A5A);

      // MFLO held behind a MULT: stalled until DONE, then reads the new LO.
      @(posedge clk); #1;
      bus.start_i = 1'b1; bus.op_i = OP_MULT;
      bus.regaData = 32'd5; bus.regbData = 32'd6;
      t0 = cyc;
      e.name = "mult_5x6"; e.hi = 32'd0; e.lo = 32'd30; e.done_cyc = t0 + LAT_MUL;
      sb.push_back(e);
      @(posedge clk); #1;
      bus.op_i = OP_MFLO;
      got = 1'b0;
      stall_ok = 1'b1;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         if (bus.done_o) begin
            got = 1'b1;
            check("mflo_held_stall_done", bus.stall_o, 0);
         end else if (!bus.stall_o) begin
            stall_ok = 1'b0;
         end
      end
      check("mflo_held_done_seen", got, 1);
      check("mflo_held_stalled", stall_ok, 1);
      @(negedge clk);
      check("mflo_held_regc", bus.regcData, 32'd30);
      check("mflo_held_stall_idle", bus.stall_o, 0);
      @(posedge clk); #1;
      bus.start_i = 1'b0;

      // Reset at iteration 10 of a DIV.
      @(posedge clk); #1;
      bus.start_i = 1'b1; bus.op_i = OP_DIV;
      bus.regaData = 32'd100; bus.regbData = 32'd3;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy",  bus.busy_o,  0);
      check("abort_stall", bus.stall_o, 0);
      check("abort_done",  bus.done_o,  0);
      check("abort_hi",    bus.hi_o,    0);
      check("abort_lo",    bus.lo_o,    0);
      repeat (40) @(posedge clk);
      check("abort_still_idle", bus.busy_o, 0);

      run_op("mult_3x4", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, LAT_MUL);

      repeat (3) @(posedge clk);
      check("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
